// File: rtl/dmem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port synchronous data memory.
// Define DMEM_ARB_CPU_PRIORITY_EN for fixed CPU-wins ties; default build is round-robin.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              MEM_memread,
  output logic              MEM_memwrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state;
  logic   cmd_dma;
  logic   cmd_we;
  logic   cpu_rd_pend;
  logic   pick_dma;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_CPU_PRIORITY_EN
  assign pick_dma = dma_req & ~cpu_req;
`else
  // last_dma remembers who won the previous arbitration; a tie goes to the other port.
  logic last_dma;
  assign pick_dma = dma_req & (~cpu_req | ~last_dma);
`endif

  assign sel_we    = pick_dma ? dma_we    : cpu_we;
  assign sel_addr  = pick_dma ? dma_addr  : cpu_addr;
  assign sel_wdata = pick_dma ? dma_wdata : cpu_wdata;

  // Stall while waiting for a grant, or while a granted CPU read has not yet returned.
  assign cpu_stall = (cpu_req & ~cpu_gnt) | (cpu_rd_pend & ~cpu_rvalid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cmd_dma      <= 1'b0;
      cmd_we       <= 1'b0;
      cpu_rd_pend  <= 1'b0;
      cpu_gnt      <= 1'b0;
      dma_gnt      <= 1'b0;
      cpu_rvalid   <= 1'b0;
      dma_rvalid   <= 1'b0;
      MEM_memread  <= 1'b0;
      MEM_memwrite <= 1'b0;
      busy         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rdata    <= '0;
      dma_rdata    <= '0;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
      last_dma     <= 1'b1;
`endif
    end else begin
      cpu_gnt      <= 1'b0;
      dma_gnt      <= 1'b0;
      cpu_rvalid   <= 1'b0;
      dma_rvalid   <= 1'b0;
      MEM_memread  <= 1'b0;
      MEM_memwrite <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req | dma_req) begin
            state        <= ISSUE;
            busy         <= 1'b1;
            cmd_dma      <= pick_dma;
            cmd_we       <= sel_we;
            mem_addr     <= sel_addr;
            mem_wdata    <= sel_wdata;
            cpu_gnt      <= ~pick_dma;
            dma_gnt      <= pick_dma;
            MEM_memread  <= ~sel_we;
            MEM_memwrite <= sel_we;
            cpu_rd_pend  <= ~pick_dma & ~sel_we;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
            last_dma     <= pick_dma;
`endif
          end
        end
        ISSUE: begin
          if (cmd_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          // Synchronous memory presents read data during this cycle.
          state <= IDLE;
          busy  <= 1'b0;
          if (cmd_dma) begin
            dma_rdata  <= mem_rdata;
            dma_rvalid <= 1'b1;
          end else begin
            cpu_rdata   <= mem_rdata;
            cpu_rvalid  <= 1'b1;
            cpu_rd_pend <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read memory model.
module tb_dmem_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_rvalid, cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dma_req, dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt, dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              MEM_memread, MEM_memwrite;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  logic [DATA_W-1:0] mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always @(posedge clk) begin
    if (MEM_memwrite) mem[mem_addr] <= mem_wdata;
    if (MEM_memread)  mem_rdata <= mem[mem_addr];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[11]   = 32'd55;
    mem_rdata = '0;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

    // Reset for two cycles with no requests
    tick(); tick();
    chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk1("rst_dma_gnt", dma_gnt, 1'b0);
    chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("rst_dma_rvalid", dma_rvalid, 1'b0);
    chk1("rst_cpu_stall", cpu_stall, 1'b0);
    chk1("rst_memread", MEM_memread, 1'b0);
    chk1("rst_memwrite", MEM_memwrite, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk32("rst_mem_wdata", mem_wdata, 32'd0);
    chk32("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk32("rst_dma_rdata", dma_rdata, 32'd0);
    reset = 1'b0;
    tick();

    // CPU write addr 10 data 20
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd10; cpu_wdata = 32'd20;
    #1;
    chk1("wr_stall_wait", cpu_stall, 1'b1);
    tick();
    chk1("wr_gnt", cpu_gnt, 1'b1);
    chk1("wr_dma_gnt", dma_gnt, 1'b0);
    chk1("wr_memwrite", MEM_memwrite, 1'b1);
    chk1("wr_memread", MEM_memread, 1'b0);
    chk32("wr_addr", 32'(mem_addr), 32'd10);
    chk32("wr_wdata", mem_wdata, 32'd20);
    chk1("wr_busy", busy, 1'b1);
    chk1("wr_stall_gnt", cpu_stall, 1'b0);
    cpu_req = 1'b0;
    tick();
    chk1("wr_memwrite_off", MEM_memwrite, 1'b0);
    chk1("wr_busy_off", busy, 1'b0);
    chk1("wr_gnt_off", cpu_gnt, 1'b0);

    // CPU read addr 10
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd10;
    tick();
    chk1("rd_gnt", cpu_gnt, 1'b1);
    chk1("rd_memread", MEM_memread, 1'b1);
    chk1("rd_memwrite", MEM_memwrite, 1'b0);
    chk1("rd_stall_issue", cpu_stall, 1'b1);
    cpu_req = 1'b0;
    tick();
    chk1("rd_resp_rvalid", cpu_rvalid, 1'b0);
    chk1("rd_resp_stall", cpu_stall, 1'b1);
    chk1("rd_resp_busy", busy, 1'b1);
    chk1("rd_resp_memread", MEM_memread, 1'b0);
    tick();
    chk1("rd_rvalid", cpu_rvalid, 1'b1);
    chk32("rd_rdata", cpu_rdata, 32'd20);
    chk1("rd_stall_done", cpu_stall, 1'b0);
    chk1("rd_busy_done", busy, 1'b0);
    tick();
    chk1("rd_rvalid_pulse", cpu_rvalid, 1'b0);
    chk32("rd_rdata_hold", cpu_rdata, 32'd20);

    // Simultaneous reads straight out of reset: CPU first, then DMA
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'd11;
    tick();
    chk1("tie_cpu_gnt", cpu_gnt, 1'b1);
    chk1("tie_dma_wait", dma_gnt, 1'b0);
    chk32("tie_addr_cpu", 32'(mem_addr), 32'd10);
    cpu_req = 1'b0;
    tick();
    chk1("tie_stall_resp", cpu_stall, 1'b1);
    tick();
    chk1("tie_cpu_rvalid", cpu_rvalid, 1'b1);
    chk32("tie_cpu_rdata", cpu_rdata, 32'd20);
    chk1("tie_stall_clear", cpu_stall, 1'b0);
    tick();
    chk1("tie_dma_gnt", dma_gnt, 1'b1);
    chk32("tie_addr_dma", 32'(mem_addr), 32'd11);
    dma_req = 1'b0;
    tick(); tick();
    chk1("tie_dma_rvalid", dma_rvalid, 1'b1);
    chk32("tie_dma_rdata", dma_rdata, 32'd55);
    chk32("tie_cpu_rdata_hold", cpu_rdata, 32'd20);

    // Both requesters held continuously (writes); last winner was DMA
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd20; cpu_wdata = 32'd1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'd21; dma_wdata = 32'd2;
    tick();
    chk1("hold1_cpu", cpu_gnt, 1'b1);
    chk1("hold1_dma", dma_gnt, 1'b0);
    tick();
    tick();
`ifdef DMEM_ARB_CPU_PRIORITY_EN
    chk1("hold2_cpu", cpu_gnt, 1'b1);
    chk1("hold2_dma", dma_gnt, 1'b0);
`else
    chk1("hold2_cpu", cpu_gnt, 1'b0);
    chk1("hold2_dma", dma_gnt, 1'b1);
`endif
    chk1("hold2_no_overlap", MEM_memread & MEM_memwrite, 1'b0);
    tick();
    tick();
    chk1("hold3_cpu", cpu_gnt, 1'b1);
    chk1("hold3_dma", dma_gnt, 1'b0);
    cpu_req = 1'b0; dma_req = 1'b0;
    tick(); tick();

    // Back-to-back DMA writes addr 0..3, data 40..43
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'd0; dma_wdata = 32'd40;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("b2b_gnt", dma_gnt, 1'b1);
      chk1("b2b_memwrite", MEM_memwrite, 1'b1);
      chk1("b2b_memread", MEM_memread, 1'b0);
      chk32("b2b_addr", 32'(mem_addr), 32'(i));
      chk32("b2b_wdata", mem_wdata, 32'(40 + i));
      dma_addr = 8'(i + 1); dma_wdata = 32'(41 + i);
      if (i == 3) dma_req = 1'b0;
      tick();
      chk1("b2b_gap_memwrite", MEM_memwrite, 1'b0);
      chk1("b2b_gap_gnt", dma_gnt, 1'b0);
    end
    chk32("b2b_mem3", mem[3], 32'd43);
    chk32("b2b_mem0", mem[0], 32'd40);

    // CPU read aborted by reset during RESP
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd10;
    tick();
    chk1("abort_gnt", cpu_gnt, 1'b1);
    cpu_req = 1'b0;
    tick();
    chk1("abort_in_resp", busy, 1'b1);
    reset = 1'b1;
    tick();
    chk1("abort_rvalid", cpu_rvalid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_memread", MEM_memread, 1'b0);
    chk1("abort_memwrite", MEM_memwrite, 1'b0);
    chk32("abort_rdata", cpu_rdata, 32'd0);
    reset = 1'b0;
    tick();
    chk1("abort_rvalid_after", cpu_rvalid, 1'b0);
    chk1("abort_stall_after", cpu_stall, 1'b0);
    chk1("abort_busy_after", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, data memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, data memory word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports cpu_req / cpu_we  input  1 / 1  CPU MEM-stage access request; we=1 is write, we=0 is read.
REQ-006 SHALL have ports cpu_addr / cpu_wdata  input  ADDR_W / DATA_W  CPU access address and write data.
REQ-007 SHALL have ports cpu_gnt / cpu_rvalid / cpu_stall  output  1 / 1 / 1  CPU grant pulse, read-data-valid pulse, pipeline stall.
REQ-008 SHALL have port cpu_rdata  output  DATA_W  CPU read data.
REQ-009 SHALL have ports dma_req / dma_we / dma_addr / dma_wdata  input  1 / 1 / ADDR_W / DATA_W  DMA/loader request, same meaning as CPU.
REQ-010 SHALL have ports dma_gnt / dma_rvalid / dma_rdata  output  1 / 1 / DATA_W  DMA grant, read-valid, read data.
REQ-011 SHALL have ports MEM_memread / MEM_memwrite  output  1 / 1  data_mem read and write strobes.
REQ-012 SHALL have ports mem_addr / mem_wdata  output  ADDR_W / DATA_W  data_mem address and write data; port mem_rdata  input  DATA_W  data_mem read data.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM with states IDLE, ISSUE, RESP.
REQ-015 In IDLE, if any req is high at a clock edge, SHALL select one winner, register its we/addr/wdata, and go to ISSUE; else stay in IDLE.
REQ-016 In ISSUE (exactly one cycle), SHALL drive mem_addr/mem_wdata from the registered command, assert exactly one of MEM_memread/MEM_memwrite, and pulse the winner's gnt.
REQ-017 From ISSUE, writes SHALL return to IDLE; reads SHALL go to RESP.
REQ-018 In RESP (one cycle), SHALL capture mem_rdata into the winner's rdata register and go to IDLE; the winner's rvalid SHALL be high for exactly the following cycle.
REQ-019 Latency from req sampled at edge N: gnt in cycle N+1; read rvalid in cycle N+3; write occupies the memory for one cycle, next grant no earlier than N+2 issue.
REQ-020 MEM_memread and MEM_memwrite SHALL never be high simultaneously and SHALL be low outside ISSUE.
REQ-021 Requesters SHALL hold req/we/addr/wdata stable until gnt; arbiter SHALL drop req sampling in ISSUE/RESP.
REQ-022 Round-robin: on simultaneous cpu_req and dma_req in IDLE, SHALL grant the port not granted last; a lone requester always wins.
REQ-023 cpu_stall SHALL equal (cpu_req AND NOT cpu_gnt) OR (CPU read outstanding AND NOT cpu_rvalid).
REQ-024 rdata registers SHALL hold value until the next read completion for that port.

Reset
REQ-025 On reset high at a clock edge SHALL enter IDLE, clear gnt, rvalid, MEM_memread, MEM_memwrite, busy, cpu_stall-internal state, mem_addr, mem_wdata, cpu_rdata, dma_rdata to 0, and set last-grant to DMA (CPU wins first tie).
REQ-026 Reset during ISSUE or RESP SHALL abort the access; no rvalid SHALL be produced for it.
REQ-027 Reset SHALL take priority over all requests in the same cycle.

Configuration
REQ-028 Macro DMEM_ARB_CPU_PRIORITY_EN defined: ties SHALL always go to CPU (fixed priority, last-grant register unused); undefined: round-robin per REQ-022.

Verification
REQ-029 Reset 2 cycles, no reqs -> all outputs 0, busy 0.
REQ-030 CPU write addr 10 data 20, then CPU read addr 10 -> MEM_memwrite high one cycle with mem_addr 10/mem_wdata 20; cpu_rvalid 3 cycles after read req with cpu_rdata 20.
REQ-031 cpu_req and dma_req both high from reset (reads, addr 10 and 11) -> CPU granted first, DMA second; cpu_stall high until cpu_rvalid; with macro defined and held reqs, CPU granted every time.
REQ-032 Back-to-back DMA writes addr 0..3 data 40..43 -> one write every 2 cycles, strobes never overlap.
REQ-033 CPU read addr 10 with reset asserted in RESP -> no cpu_rvalid, FSM in IDLE next cycle, strobes 0.
